div_8bit_seq: RTL and testbench

Sequential unsigned 8-bit divider that performs the inverse of the 8x8 multiply in the filter datapath. It computes the quotient and remainder of two 8-bit operands using radix-2 restoring division, one quotient bit per clock. It serves coefficient normalisation and gain-scaling paths where a one-result-per-ten-cycles rate is acceptable. A start/busy/done handshake connects it to a controlling FSM.

---
 rtl/fir_arith_pkg.sv | 6 +
 rtl/div_8bit_seq_if.sv | 14 +
 rtl/rca_8bit.sv | 16 +
 rtl/div_8bit_seq.sv | 66 ++++++
 tb/tb_div_8bit_seq.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/fir_arith_pkg.sv
// fir_arith_pkg: shared operand width, divide-by-zero quotient and divider state encoding
package fir_arith_pkg;
  localparam int DIV_W = 8;
  localparam logic [DIV_W-1:0] DBZ_QUOT = 8'hFF;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/div_8bit_seq_if.sv
// div_8bit_seq_if: start/busy/done handshake and operand/result bus of the divider
interface div_8bit_seq_if;
  import fir_arith_pkg::*;
  logic start;
  logic [DIV_W-1:0] A;
  logic [DIV_W-1:0] B;
  logic [DIV_W-1:0] Q;
  logic [DIV_W-1:0] R;
  logic busy;
  logic done;
  logic dbz;
  modport master (output start, A, B, input Q, R, busy, done, dbz);
  modport slave (input start, A, B, output Q, R, busy, done, dbz);
endinterface

// File: rtl/rca_8bit.sv
// rca_8bit: 8-bit ripple-carry adder
module rca_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [8:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[8];
endmodule

// File: rtl/div_8bit_seq.sv
// div_8bit_seq: radix-2 restoring unsigned 8/8 divider, one quotient bit per clock
module div_8bit_seq
  import fir_arith_pkg::*;
(
  input logic clk,
  input logic rst,
  div_8bit_seq_if.slave io
);
  state_t state;
  logic [DIV_W-1:0] dvd, dvs, rem, diff, nxt_rem, nxt_dvd;
  logic [DIV_W:0] rem9;
  logic [2:0] cnt;
  logic cout, nb;
  // The kept remainder is always below the divisor, so only the shifted value needs 9 bits
  assign rem9 = {rem, dvd[DIV_W-1]};
  rca_8bit u_sub (.a(rem9[DIV_W-1:0]), .b(~dvs), .cin(1'b1), .s(diff), .cout(cout));
  assign nb      = rem9[DIV_W] | cout;
  assign nxt_rem = nb ? diff : rem9[DIV_W-1:0];
  assign nxt_dvd = {dvd[DIV_W-2:0], nb};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      cnt     <= '0;
      io.Q    <= '0;
      io.R    <= '0;
      io.busy <= 1'b0;
      io.done <= 1'b0;
      io.dbz  <= 1'b0;
    end else begin
      io.done <= 1'b0;
      if (state != CALC) begin
        if (io.start && io.B == '0) begin
          state   <= DONE;
          io.done <= 1'b1;
          io.Q    <= DBZ_QUOT;
          io.R    <= io.A;
          io.dbz  <= 1'b1;
        end else if (io.start) begin
          state   <= CALC;
          io.busy <= 1'b1;
          dvd     <= io.A;
          dvs     <= io.B;
          rem     <= '0;
          cnt     <= '0;
        end else begin
          state <= IDLE;
        end
      end else begin
        dvd <= nxt_dvd;
        rem <= nxt_rem;
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          state   <= DONE;
          io.busy <= 1'b0;
          io.done <= 1'b1;
          io.Q    <= nxt_dvd;
          io.R    <= nxt_rem;
          io.dbz  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_div_8bit_seq.sv
// tb_div_8bit_seq: vector table, handshake corner cases and randomised sweep for div_8bit_seq
module tb_div_8bit_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  div_8bit_seq_if bus ();
  div_8bit_seq dut (.clk(clk), .rst(rst), .io(bus.slave));
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b, q, r;
    logic       dbz;
    int         lat;
  } vec_t;
  vec_t tbl[8];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endfunction

  // Waits (bounded) for done, counting sampled cycles since the accepting edge and busy cycles seen
  task automatic wait_done(output int lat, output int nbusy);
    lat = 1;
    nbusy = 0;
    while (!bus.done && lat < 30) begin
      nbusy += int'(bus.busy);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_div(input logic [7:0] a, input logic [7:0] b, output int lat, output int nbusy);
    @(negedge clk);
    launch(a, b);
    wait_done(lat, nbusy);
  endtask

  int lat, nbusy, seen;
  logic [7:0] ra, rb;
  initial begin
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    tbl[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 9};
    tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9};
    tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9};
    tbl[3] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9};
    tbl[4] = '{8'd100, 8'd0,   8'hFF,  8'd100, 1'b1, 1};
    tbl[5] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9};
    tbl[6] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 1};
    tbl[7] = '{8'd128, 8'd128, 8'd1,   8'd0,   1'b0, 9};
    repeat (2) @(negedge clk);
    chk("reset_q", bus.Q, 0);
    chk("reset_r", bus.R, 0);
    chk("reset_flags", {bus.busy, bus.done, bus.dbz}, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_div(tbl[i].a, tbl[i].b, lat, nbusy);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), nbusy, tbl[i].lat - 1);
      chk($sformatf("vec%0d_q", i), bus.Q, tbl[i].q);
      chk($sformatf("vec%0d_r", i), bus.R, tbl[i].r);
      chk($sformatf("vec%0d_dbz", i), bus.dbz, tbl[i].dbz);
      chk($sformatf("vec%0d_busy_at_done", i), bus.busy, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), bus.done, 0);
    end

    // A start during CALC must be ignored
    @(negedge clk);
    launch(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.A = 8'd9;
    bus.B = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, nbusy);
    chk("ignored_lat", lat, 5);
    chk("ignored_q", bus.Q, 28);
    chk("ignored_r", bus.R, 4);
    // Back-to-back start in the DONE cycle
    launch(8'd9, 8'd3);
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_done_low", bus.done, 0);
    wait_done(lat, nbusy);
    chk("b2b_lat", lat, 9);
    chk("b2b_q", bus.Q, 3);
    chk("b2b_r", bus.R, 0);

    // Reset in the middle of an iteration
    @(negedge clk);
    launch(8'd77, 8'd5);
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_q", bus.Q, 0);
    chk("rst_r", bus.R, 0);
    chk("rst_flags", {bus.busy, bus.done, bus.dbz}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen += int'(bus.done) + int'(bus.busy);
    end
    chk("rst_no_done", seen, 0);
    do_div(8'd77, 8'd5, lat, nbusy);
    chk("after_rst_lat", lat, 9);
    chk("after_rst_q", bus.Q, 15);
    chk("after_rst_r", bus.R, 2);

    // Randomised sweep against plain integer division
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      do_div(ra, rb, lat, nbusy);
      if (rb == 0) begin
        chk("rnd_dbz_q", bus.Q, 255);
        chk("rnd_dbz_r", bus.R, ra);
        chk("rnd_dbz_flag", bus.dbz, 1);
        chk("rnd_dbz_lat", lat, 1);
      end else begin
        chk("rnd_q", bus.Q, ra / rb);
        chk("rnd_r", bus.R, ra % rb);
        chk("rnd_identity", int'(bus.Q) * int'(rb) + int'(bus.R), ra);
        chk("rnd_r_lt_b", int'(bus.R < rb), 1);
        chk("rnd_dbz_flag", bus.dbz, 0);
        chk("rnd_lat", lat, 9);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
